// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS x N-bit operands LSW first
// through one N-bit adder slice, returning the full result plus NZCV flags.
module mp_add_seq #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_sub,
    input  logic [N*WORDS-1:0]   a_in,
    input  logic [N*WORDS-1:0]   b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   result,
    output logic                 flag_n,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic                 busy
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [N-1:0]    a_w   [WORDS];
    logic [N-1:0]    b_w   [WORDS];
    logic [N-1:0]    res_w [WORDS];
    logic            op_q;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            zacc;

    logic [N-1:0]    aw;
    logic [N-1:0]    bw;
    logic [N-1:0]    s;
    logic            co;
    logic            last;

    // Single add slice; subtraction is A + ~B with the initial carry set to 1.
    always_comb begin
        aw      = a_w[idx];
        bw      = b_w[idx] ^ {N{op_q}};
        {co, s} = {1'b0, aw} + {1'b0, bw} + {{N{1'b0}}, carry};
        last    = (idx == IW'(WORDS - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                a_w[i]   <= '0;
                b_w[i]   <= '0;
                res_w[i] <= '0;
            end
            op_q   <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            zacc   <= 1'b0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < WORDS; i++) begin
                            a_w[i] <= a_in[i*N +: N];
                            b_w[i] <= b_in[i*N +: N];
                        end
                        op_q  <= op_sub;
                        idx   <= '0;
                        carry <= op_sub;
                        zacc  <= 1'b1;
                    end
                end
                RUN: begin
                    res_w[idx] <= s;
                    carry      <= co;
                    zacc       <= zacc & (s == '0);
                    if (last) begin
                        flag_c <= co;
                        flag_n <= s[N-1];
                        flag_z <= zacc & (s == '0);
                        flag_v <= (aw[N-1] & bw[N-1] & ~s[N-1]) |
                                  (~aw[N-1] & ~bw[N-1] & s[N-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            result[i*N +: N] = res_w[i];
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: stimulus pushes model results into a queue,
// a monitor pops and compares on each completed result handshake.
module tb_mp_add_seq;

    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct {
        logic [W-1:0] r;
        logic         n;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c;
    logic          flag_v;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;
    exp_t sb[$];

    mp_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-width arithmetic, carry as "no borrow" for subtract.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t       e;
        logic [W:0] full;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            e.c  = (a >= b);
            e.v  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            e.c  = full[W];
            e.v  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end
        e.r = full[W-1:0];
        e.n = e.r[W-1];
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] nzcv(input logic n, input logic z, input logic c, input logic v);
        return W'({n, z, c, v});
    endfunction

    // Monitor: compare whenever a result handshake is about to complete.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", W'(1), W'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.r);
                chk("nzcv", nzcv(flag_n, flag_z, flag_c, flag_v), nzcv(e.n, e.z, e.c, e.v));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; returns after the accept edge (+1).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit push);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) chk("in_ready_timeout", W'(0), W'(1));
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        op_sub   = sub;
        if (push) sb.push_back(model(a, b, sub));
        tick();
        in_valid = 1'b0;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
    endtask

    task automatic wait_valid(input bit check_lat);
        int cycles = 0;
        while (!out_valid && cycles < 50) begin
            if (check_lat && cycles > 0 && cycles < WORDS) chk("busy_in_run", W'(busy), W'(1));
            tick();
            cycles++;
        end
        if (check_lat) chk("latency", W'(cycles), W'(WORDS));
        else if (!out_valid) chk("valid_timeout", W'(0), W'(1));
    endtask

    // Wait for handshake; optional random backpressure meanwhile.
    task automatic wait_done(input bit rand_bp);
        int guard = 0;
        while (out_valid && guard < 200) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        if (out_valid) chk("done_timeout", W'(0), W'(1));
        out_ready = 1'b1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        issue(a, b, sub, 1'b1);
        wait_valid(1'b1);
        wait_done(1'b0);
        chk("in_ready_after_hs", W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        exp_t         e;

        ones      = '1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("reset_result", result, '0);
        chk("reset_flags", nzcv(flag_n, flag_z, flag_c, flag_v), '0);
        chk("reset_valid_busy", W'({out_valid, busy}), '0);
        rst_n = 1'b1;
        tick();
        chk("reset_in_ready", W'(in_ready), W'(1));

        // Directed corner cases
        run_op(ones, W'(1), 1'b0);
        run_op(W'(5), W'(7), 1'b1);
        run_op({1'b0, ones[W-2:0]}, W'(1), 1'b0);
        run_op(W'(64'hFFFF_FFFF), W'(1), 1'b0);
        run_op(W'(64'h1_0000_0000), W'(1), 1'b1);
        run_op({1'b1, {(W-1){1'b0}}}, W'(1), 1'b1);
        run_op(ones, ones, 1'b1);

        // Backpressure: result must stay put, nothing accepted
        out_ready = 1'b0;
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        e  = model(ra, rb, 1'b0);
        issue(ra, rb, 1'b0, 1'b1);
        wait_valid(1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a_in     = {$urandom, $urandom, $urandom, $urandom};
            b_in     = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("bp_result", result, e.r);
            chk("bp_flags", nzcv(flag_n, flag_z, flag_c, flag_v), nzcv(e.n, e.z, e.c, e.v));
            chk("bp_state", W'({in_ready, out_valid, busy}), W'(3'b010));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release", W'({in_ready, out_valid}), W'(2'b10));

        // Reset in the middle of RUN (idx == 2): no output, immediate clear
        issue({$urandom, $urandom, $urandom, $urandom}, W'(12345), 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrun_result", result, '0);
        chk("midrun_flags", nzcv(flag_n, flag_z, flag_c, flag_v), '0);
        chk("midrun_valid_busy", W'({out_valid, busy}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(W'(3), W'(4), 1'b0);

        // Random operations with random backpressure
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) rb[W-1:N] = ra[W-1:N];
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            wait_valid(1'b0);
            wait_done(1'b1);
        end

        repeat (3) tick();
        chk("scoreboard_drain", W'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
